// File: rtl/shift_unit_seq.sv
// Multi-cycle SLL/SRL/SRA/ROR shifter, one bit per clock, with an idle parallel-load path.
// Latency: done pulses shamt cycles after the accepting edge (shamt=0 -> next cycle); busy lasts shamt+1 cycles.
// Backpressure: start/load are accepted only in IDLE; while busy they are ignored, so the controller stalls on busy.
module shift_unit_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               start,
    input  logic               load,
    input  logic [1:0]         mode,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   dataIn,
    output logic [WIDTH-1:0]   dataOut,
    output logic               serialOut,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;

    state_t             state, state_nxt;
    logic [SHAMT_W-1:0] count, count_nxt;
    logic [1:0]         mode_q, mode_nxt;
    logic [WIDTH-1:0]   data_nxt, step_dat;
    logic               serial_nxt, step_bit;
    logic               done_nxt;

    // busy is a pure decode of the state register, so it is glitch-free and reset-clean.
    assign busy = (state != IDLE);

    // Single 1-bit step of the working register under the mode latched at acceptance.
    always_comb begin
        step_dat = dataOut;
        step_bit = dataOut[0];
        case (mode_q)
            MODE_SLL: begin
                step_dat = {dataOut[WIDTH-2:0], 1'b0};
                step_bit = dataOut[WIDTH-1];
            end
            MODE_SRL: step_dat = {1'b0, dataOut[WIDTH-1:1]};
            MODE_SRA: step_dat = {dataOut[WIDTH-1], dataOut[WIDTH-1:1]};
            default:  step_dat = {dataOut[0], dataOut[WIDTH-1:1]};
        endcase
    end

    // Next-state and next-datapath decode; every register holds unless its state says otherwise.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        mode_nxt   = mode_q;
        data_nxt   = dataOut;
        serial_nxt = serialOut;
        case (state)
            IDLE: begin
                // start has priority over load when both are asserted.
                if (start) begin
                    data_nxt   = dataIn;
                    count_nxt  = shamt;
                    mode_nxt   = mode;
                    serial_nxt = 1'b0;
                    state_nxt  = (shamt == '0) ? DONE : SHIFT;
                end else if (load) begin
                    data_nxt = dataIn;
                end
            end
            SHIFT: begin
                data_nxt   = step_dat;
                serial_nxt = step_bit;
                count_nxt  = count - SHAMT_W'(1);
                if (count == SHAMT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        done_nxt = (state_nxt == DONE);
    end

    // State and datapath registers; reset clears everything without waiting for a clock.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            count     <= '0;
            mode_q    <= 2'b00;
            dataOut   <= '0;
            serialOut <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            mode_q    <= mode_nxt;
            dataOut   <= data_nxt;
            serialOut <= serial_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq: table of shift operations plus hand sequences for
// load priority, busy-time interference and asynchronous reset in the middle of a shift.
// Expected results are hand-computed constants.
module tb_shift_unit_seq;

    logic        CLK;
    logic        RST_N;
    logic        start;
    logic        load;
    logic [1:0]  mode;
    logic [4:0]  shamt;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic        serialOut;
    logic        busy;
    logic        done;

    int n_checks;
    int n_fail;

    shift_unit_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .start     (start),
        .load      (load),
        .mode      (mode),
        .shamt     (shamt),
        .dataIn    (dataIn),
        .dataOut   (dataOut),
        .serialOut (serialOut),
        .busy      (busy),
        .done      (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  m;
        logic [4:0]  sa;
        logic [31:0] din;
        logic [31:0] exp_d;
        logic        exp_so;
    } vec_t;

    vec_t vt[10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Issue one operation, then track busy/done edge by edge and check timing and result.
    task automatic run_op(input string nm, input logic [1:0] m, input logic [4:0] sa,
                          input logic [31:0] din, input logic [31:0] exp_d, input logic exp_so,
                          input bit with_load, input bit interfere);
        int          busy_cnt;
        int          done_at;
        logic [31:0] res_d;
        logic        res_so;
        logic        done_end;
        busy_cnt = 0;
        done_at  = -1;
        res_d    = '0;
        res_so   = 1'b0;
        done_end = 1'b1;
        @(negedge CLK);
        start  = 1'b1;
        load   = with_load;
        mode   = m;
        shamt  = sa;
        dataIn = din;
        @(posedge CLK);
        #1;
        // Scramble operands: they must only matter at the accepting edge.
        start  = 1'b0;
        load   = 1'b0;
        mode   = ~m;
        shamt  = ~sa;
        dataIn = 32'h5A5A_5A5A;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) begin
                @(posedge CLK);
                #1;
            end
            if (busy) busy_cnt++;
            if (done && done_at < 0) begin
                done_at = k;
                res_d   = dataOut;
                res_so  = serialOut;
            end
            if (interfere && k == 2) begin
                start  = 1'b1;
                load   = 1'b1;
                shamt  = 5'd3;
                dataIn = 32'h0;
            end else if (interfere && k == 3) begin
                start = 1'b0;
                load  = 1'b0;
            end
            if (!busy) begin
                done_end = done;
                break;
            end
        end
        check({nm, " done_latency"}, 32'(done_at), 32'(sa));
        check({nm, " busy_cycles"}, 32'(busy_cnt), 32'(sa) + 32'd1);
        check({nm, " dataOut"}, res_d, exp_d);
        check({nm, " serialOut"}, {31'b0, res_so}, {31'b0, exp_so});
        check({nm, " done_cleared"}, {31'b0, done_end}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        vt[0] = '{2'b00, 5'd4,  32'h0000_00F1, 32'h0000_0F10, 1'b0};
        vt[1] = '{2'b01, 5'd1,  32'h8000_0003, 32'h4000_0001, 1'b1};
        vt[2] = '{2'b00, 5'd0,  32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
        vt[3] = '{2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0};
        vt[4] = '{2'b11, 5'd8,  32'h1234_5678, 32'h7812_3456, 1'b0};
        vt[5] = '{2'b00, 5'd31, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vt[6] = '{2'b01, 5'd31, 32'h8000_0000, 32'h0000_0001, 1'b0};
        vt[7] = '{2'b11, 5'd31, 32'h8000_0001, 32'h0000_0003, 1'b0};
        vt[8] = '{2'b10, 5'd3,  32'h7000_000F, 32'h0E00_0001, 1'b1};
        vt[9] = '{2'b11, 5'd1,  32'h0000_0001, 32'h8000_0000, 1'b1};

        start  = 1'b0;
        load   = 1'b0;
        mode   = 2'b00;
        shamt  = 5'd0;
        dataIn = 32'h0;
        RST_N  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset dataOut", dataOut, 32'h0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset serialOut", {31'b0, serialOut}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Plain parallel load while idle.
        @(negedge CLK);
        load   = 1'b1;
        dataIn = 32'hDEAD_BEEF;
        @(posedge CLK);
        #1;
        load = 1'b0;
        check("load dataOut", dataOut, 32'hDEAD_BEEF);
        check("load busy", {31'b0, busy}, 32'd0);
        check("load done", {31'b0, done}, 32'd0);

        // start and load together: start wins.
        run_op("start_over_load", 2'b00, 5'd1, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vt[i].m, vt[i].sa, vt[i].din, vt[i].exp_d,
                   vt[i].exp_so, 1'b0, 1'b0);
        end

        // Load leaves serialOut alone (last op left it at 1).
        @(negedge CLK);
        load   = 1'b1;
        dataIn = 32'h1111_1111;
        @(posedge CLK);
        #1;
        load = 1'b0;
        check("load2 dataOut", dataOut, 32'h1111_1111);
        check("load2 serialOut", {31'b0, serialOut}, 32'd1);
        check("load2 done", {31'b0, done}, 32'd0);

        // start/load pulsed mid-shift must be ignored.
        run_op("interfere", 2'b00, 5'd10, 32'h0000_0003, 32'h0000_0C00, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset after 5 steps of an SLL by 20.
        @(negedge CLK);
        start  = 1'b1;
        mode   = 2'b00;
        shamt  = 5'd20;
        dataIn = 32'hFFFF_FFFF;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        check("midshift dataOut", dataOut, 32'hFFFF_FFE0);
        check("midshift busy", {31'b0, busy}, 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        check("async_rst dataOut", dataOut, 32'h0);
        check("async_rst busy", {31'b0, busy}, 32'd0);
        check("async_rst done", {31'b0, done}, 32'd0);
        check("async_rst serialOut", {31'b0, serialOut}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        run_op("after_rst", 2'b00, 5'd2, 32'h0000_0003, 32'h0000_000C, 1'b0, 1'b0, 1'b0);

        repeat (2) @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
